// File: rtl/input_interface_pkg.sv
// Shared definitions for the IEEE754 operand unpacking front end:
// word sizes, format field widths and the unpacked-operand record.
package input_interface_pkg;

   localparam int REG_SIZE                = 64;
   localparam logic S_MODE                = 1'b0;
   localparam logic D_MODE                = 1'b1;

   localparam int S_EXP_W                 = 8;
   localparam int S_MAN_W                 = 23;
   localparam int D_EXP_W                 = 11;
   localparam int D_MAN_W                 = 52;

   localparam int INPUT_INTERFACE_INT_OUT = 53;

   // Field order matches the output port grouping of one operand.
   typedef struct packed {
      logic [INPUT_INTERFACE_INT_OUT-1:0] mant;
      logic [D_EXP_W-1:0]                 exp;
      logic                               sign;
      logic                               nan;
      logic                               inf;
      logic                               zero;
      logic                               den;
      logic                               err;
   } unpacked_t;

endpackage

// File: rtl/input_interface_fp_unpack.sv
// Combinational unpacker for one IEEE754 operand: splits fields, classifies
// the value and restores the hidden bit for normal numbers.
module fp_unpack
   import input_interface_pkg::*;
(
   input  logic                               mode_i,
   input  logic [REG_SIZE-1:0]                op_i,
   output logic [INPUT_INTERFACE_INT_OUT-1:0] int_o,
   output logic [D_EXP_W-1:0]                 exp_o,
   output logic                               sign_o,
   output logic                               nan_o,
   output logic                               inf_o,
   output logic                               zero_o,
   output logic                               den_o,
   output logic                               err_o
);

   localparam logic [INPUT_INTERFACE_INT_OUT-1:0] S_HIDDEN = INPUT_INTERFACE_INT_OUT'(1) << S_MAN_W;
   localparam logic [INPUT_INTERFACE_INT_OUT-1:0] D_HIDDEN = INPUT_INTERFACE_INT_OUT'(1) << D_MAN_W;

   logic [D_EXP_W-1:0]                 exp_f;
   logic [D_MAN_W-1:0]                 man_f;
   logic [INPUT_INTERFACE_INT_OUT-1:0] hidden;
   logic                               exp_ones;
   logic                               exp_zero;
   logic                               man_zero;
   logic                               man_msb;
   logic                               normal;

   always_comb begin
      if (mode_i == S_MODE) begin
         sign_o   = op_i[S_EXP_W+S_MAN_W];
         exp_f    = {{(D_EXP_W-S_EXP_W){1'b0}}, op_i[S_EXP_W+S_MAN_W-1:S_MAN_W]};
         man_f    = {{(D_MAN_W-S_MAN_W){1'b0}}, op_i[S_MAN_W-1:0]};
         exp_ones = &op_i[S_EXP_W+S_MAN_W-1:S_MAN_W];
         man_msb  = op_i[S_MAN_W-1];
         hidden   = S_HIDDEN;
      end else begin
         sign_o   = op_i[D_EXP_W+D_MAN_W];
         exp_f    = op_i[D_EXP_W+D_MAN_W-1:D_MAN_W];
         man_f    = op_i[D_MAN_W-1:0];
         exp_ones = &op_i[D_EXP_W+D_MAN_W-1:D_MAN_W];
         man_msb  = op_i[D_MAN_W-1];
         hidden   = D_HIDDEN;
      end

      exp_zero = (exp_f == '0);
      man_zero = (man_f == '0);
      normal   = !exp_ones && !exp_zero;

      inf_o    = exp_ones &&  man_zero;
      nan_o    = exp_ones && !man_zero;
      zero_o   = exp_zero &&  man_zero;
      den_o    = exp_zero && !man_zero;
      // A quiet NaN has the mantissa MSB set; anything else is signalling.
      err_o    = nan_o && !man_msb;

      int_o    = {1'b0, man_f} | (normal ? hidden : '0);
      // Subnormals share the scale of exponent 1, so report that instead of 0.
      exp_o    = exp_zero ? D_EXP_W'(1) : exp_f;
   end

endmodule

// File: rtl/input_interface.sv
// Two-stage input pipeline: S1 captures raw operands, S2 holds the unpacked
// and classified results with a valid/ready handshake on both sides.
module input_interface
   import input_interface_pkg::*;
(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               mode,
   input  logic [REG_SIZE-1:0]                inA,
   input  logic [REG_SIZE-1:0]                inB,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [INPUT_INTERFACE_INT_OUT-1:0] intA,
   output logic [INPUT_INTERFACE_INT_OUT-1:0] intB,
   output logic [D_EXP_W-1:0]                 expA,
   output logic [D_EXP_W-1:0]                 expB,
   output logic                               signA,
   output logic                               signB,
   output logic                               nanA,
   output logic                               nanB,
   output logic                               infA,
   output logic                               infB,
   output logic                               zeroA,
   output logic                               zeroB,
   output logic                               denA,
   output logic                               denB,
   output logic                               errA,
   output logic                               errB,
   output logic                               err_sticky,
   input  logic                               clear,
   output logic [15:0]                        op_count
);

   logic                s1_valid_q, s1_valid_d;
   logic                s2_valid_q, s2_valid_d;
   logic                s1_mode_q;
   logic [REG_SIZE-1:0] s1_op_q [2];
   unpacked_t           s2_q [2];
   unpacked_t           unp [2];
   logic                err_sticky_q, err_sticky_d;
   logic [15:0]         op_count_q, op_count_d;

   logic                in_xfer;
   logic                out_xfer;
   logic                s1_adv;

   for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      logic [INPUT_INTERFACE_INT_OUT-1:0] int_w;
      logic [D_EXP_W-1:0]                 exp_w;
      logic                               sign_w, nan_w, inf_w, zero_w, den_w, err_w;

      fp_unpack u_fp_unpack (
         .mode_i (s1_mode_q),
         .op_i   (s1_op_q[gi]),
         .int_o  (int_w),
         .exp_o  (exp_w),
         .sign_o (sign_w),
         .nan_o  (nan_w),
         .inf_o  (inf_w),
         .zero_o (zero_w),
         .den_o  (den_w),
         .err_o  (err_w)
      );

      assign unp[gi] = {int_w, exp_w, sign_w, nan_w, inf_w, zero_w, den_w, err_w};
   end

   always_comb begin
      out_xfer = s2_valid_q && out_ready;
      s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
      // Gated by rst_n so upstream sees not-ready for the whole reset window.
      in_ready = rst_n && (!s1_valid_q || s1_adv);
      in_xfer  = in_valid && in_ready;

      s1_valid_d = in_xfer || (s1_valid_q && !s1_adv);
      s2_valid_d = s1_adv  || (s2_valid_q && !out_xfer);

      err_sticky_d = err_sticky_q;
      op_count_d   = op_count_q;
      if (clear) begin
         err_sticky_d = 1'b0;
         op_count_d   = '0;
      end else if (out_xfer) begin
         err_sticky_d = err_sticky_q || s2_q[0].err || s2_q[1].err;
         op_count_d   = op_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q   <= 1'b0;
         s2_valid_q   <= 1'b0;
         s1_mode_q    <= 1'b0;
         s1_op_q[0]   <= '0;
         s1_op_q[1]   <= '0;
         s2_q[0]      <= '0;
         s2_q[1]      <= '0;
         err_sticky_q <= 1'b0;
         op_count_q   <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s2_valid_q   <= s2_valid_d;
         err_sticky_q <= err_sticky_d;
         op_count_q   <= op_count_d;
         if (in_xfer) begin
            s1_mode_q  <= mode;
            s1_op_q[0] <= inA;
            s1_op_q[1] <= inB;
         end
         if (s1_adv) begin
            s2_q[0] <= unp[0];
            s2_q[1] <= unp[1];
         end
      end
   end

   assign out_valid  = s2_valid_q;
   assign err_sticky = err_sticky_q;
   assign op_count   = op_count_q;

   assign intA  = s2_q[0].mant;
   assign expA  = s2_q[0].exp;
   assign signA = s2_q[0].sign;
   assign nanA  = s2_q[0].nan;
   assign infA  = s2_q[0].inf;
   assign zeroA = s2_q[0].zero;
   assign denA  = s2_q[0].den;
   assign errA  = s2_q[0].err;

   assign intB  = s2_q[1].mant;
   assign expB  = s2_q[1].exp;
   assign signB = s2_q[1].sign;
   assign nanB  = s2_q[1].nan;
   assign infB  = s2_q[1].inf;
   assign zeroB = s2_q[1].zero;
   assign denB  = s2_q[1].den;
   assign errB  = s2_q[1].err;

endmodule

// File: tb/tb_input_interface.sv
// Self-checking bench for input_interface: directed format cases, backpressure,
// reset/clear behaviour and a randomized run against a queue-based model.
module tb_input_interface;
   import input_interface_pkg::*;

   typedef struct packed {
      logic [52:0] iv;
      logic [10:0] ex;
      logic        s, n, i, z, d, e;
   } opx_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        mode = 1'b0;
   logic [63:0] inA = '0, inB = '0;
   logic        in_valid = 1'b0, out_ready = 1'b0, clear = 1'b0;
   logic        in_ready, out_valid;
   logic [52:0] intA, intB;
   logic [10:0] expA, expB;
   logic        signA, signB, nanA, nanB, infA, infB, zeroA, zeroB, denA, denB;
   logic        errA, errB, err_sticky;
   logic [15:0] op_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   input_interface dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .inA(inA), .inB(inB),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .intA(intA), .intB(intB), .expA(expA), .expB(expB),
      .signA(signA), .signB(signB), .nanA(nanA), .nanB(nanB),
      .infA(infA), .infB(infB), .zeroA(zeroA), .zeroB(zeroB),
      .denA(denA), .denB(denB), .errA(errA), .errB(errB),
      .err_sticky(err_sticky), .clear(clear), .op_count(op_count)
   );

   // Reference: decode an operand straight from the IEEE754 field rules.
   function automatic opx_t ref_op(logic m, logic [63:0] w);
      opx_t        r;
      int          ew, mw;
      logic [63:0] emax, e, mn;
      ew   = (m == S_MODE) ? 8 : 11;
      mw   = (m == S_MODE) ? 23 : 52;
      emax = (64'd1 << ew) - 64'd1;
      e    = (w >> mw) & emax;
      mn   = w & ((64'd1 << mw) - 64'd1);
      r    = '0;
      r.s  = w[ew+mw];
      r.iv = mn[52:0];
      r.ex = e[10:0];
      if (e == emax) begin
         if (mn == 64'd0) r.i = 1'b1;
         else begin
            r.n = 1'b1;
            r.e = (mn[mw-1] == 1'b0);
         end
      end else if (e == 64'd0) begin
         r.ex = 11'd1;
         if (mn == 64'd0) r.z = 1'b1;
         else r.d = 1'b1;
      end else begin
         r.iv = 53'(mn + (64'd1 << mw));
      end
      return r;
   endfunction

   function automatic logic [139:0] expect_pair(logic m, logic [63:0] a, logic [63:0] b);
      return {ref_op(m, a), ref_op(m, b)};
   endfunction

   function automatic logic [139:0] obs_now();
      return {intA, expA, signA, nanA, infA, zeroA, denA, errA,
              intB, expB, signB, nanB, infB, zeroB, denB, errB};
   endfunction

   // Random operand biased towards zero/den/inf/nan encodings; S mode gets junk upper bits.
   function automatic logic [63:0] rand_op(logic m);
      int          ew, mw;
      logic [63:0] e, mn, w;
      ew = (m == S_MODE) ? 8 : 11;
      mw = (m == S_MODE) ? 23 : 52;
      case ($urandom_range(0, 3))
         0:       e = '0;
         1:       e = (64'd1 << ew) - 64'd1;
         default: e = 64'($urandom_range(1, (1 << ew) - 2));
      endcase
      case ($urandom_range(0, 3))
         0:       mn = '0;
         1:       mn = 64'd1 << (mw - 1);
         2:       mn = 64'd1;
         default: mn = {$urandom, $urandom} & ((64'd1 << mw) - 64'd1);
      endcase
      w = (64'($urandom_range(0, 1)) << (ew + mw)) | (e << mw) | mn;
      if (m == S_MODE) w = w | {$urandom, 32'h0};
      return w;
   endfunction

   // Presents one op with out_ready=1; returns in the cycle where it sits in S2.
   task automatic drive_single(input logic m, input logic [63:0] a, input logic [63:0] b);
      mode = m; inA = a; inB = b; in_valid = 1'b1; out_ready = 1'b1; clear = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, err_sticky, op_count} !== 19'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got valid=%b ready=%b sticky=%b count=%0d, expected all 0",
                  out_valid, in_ready, err_sticky, op_count);
      end
      checks++;
      if (obs_now() !== 140'd0) begin
         errors++;
         $display("FAIL reset_data: got %h, expected 0", obs_now());
      end
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b, expected 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_s_normal();
      logic [63:0] a, b;
      a = 64'hDEADBEEF_3F800000;
      b = rand_op(S_MODE);
      mode = S_MODE; inA = a; inB = b; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL s_normal_in_ready: got %b, expected 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_cycle1: out_valid got %b, expected 0", out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL latency_cycle2: out_valid got %b, expected 1", out_valid);
      end
      checks++;
      if (intA !== 53'h800000 || expA !== 11'h07F) begin
         errors++;
         $display("FAIL s_one_fields: got int=%h exp=%h, expected int=800000 exp=07f", intA, expA);
      end
      checks++;
      if ({signA, nanA, infA, zeroA, denA, errA} !== 6'b0) begin
         errors++;
         $display("FAIL s_one_flags: got %b, expected 000000",
                  {signA, nanA, infA, zeroA, denA, errA});
      end
      checks++;
      if (obs_now() !== expect_pair(S_MODE, a, b)) begin
         errors++;
         $display("FAIL s_normal_model: got %h, expected %h", obs_now(), expect_pair(S_MODE, a, b));
      end
      $display("xfer S A=%h B=%h", a, b);
   endtask

   task automatic test_d_special();
      logic [63:0] a, b;
      a = 64'h7FF0000000000000;
      b = 64'hFFF8000000000000;
      drive_single(D_MODE, a, b);
      checks++;
      if ({infA, nanB, signB, errB} !== 4'b1110) begin
         errors++;
         $display("FAIL d_inf_qnan: got infA=%b nanB=%b signB=%b errB=%b, expected 1 1 1 0",
                  infA, nanB, signB, errB);
      end
      checks++;
      if (obs_now() !== expect_pair(D_MODE, a, b)) begin
         errors++;
         $display("FAIL d_inf_qnan_model: got %h, expected %h", obs_now(), expect_pair(D_MODE, a, b));
      end
      $display("xfer D A=%h B=%h", a, b);
      a = 64'h7FF0000000000001;
      b = rand_op(D_MODE);
      drive_single(D_MODE, a, b);
      checks++;
      if ({nanA, errA} !== 2'b11) begin
         errors++;
         $display("FAIL d_snan: got nanA=%b errA=%b, expected 1 1", nanA, errA);
      end
      checks++;
      if (obs_now() !== expect_pair(D_MODE, a, b)) begin
         errors++;
         $display("FAIL d_snan_model: got %h, expected %h", obs_now(), expect_pair(D_MODE, a, b));
      end
      $display("xfer D A=%h B=%h", a, b);
      @(posedge clk); #1;
      checks++;
      if (err_sticky !== 1'b1) begin
         errors++;
         $display("FAIL d_snan_sticky: got %b, expected 1", err_sticky);
      end
   endtask

   task automatic test_s_special();
      logic [63:0] a, b;
      a = 64'h00000000_00000001;
      b = 64'h12345678_80000000;
      drive_single(S_MODE, a, b);
      checks++;
      if ({denA, intA, expA} !== {1'b1, 53'd1, 11'd1}) begin
         errors++;
         $display("FAIL s_den: got den=%b int=%h exp=%h, expected 1 1 1", denA, intA, expA);
      end
      checks++;
      if ({zeroB, signB, expB} !== {1'b1, 1'b1, 11'd1}) begin
         errors++;
         $display("FAIL s_negzero: got zero=%b sign=%b exp=%h, expected 1 1 1", zeroB, signB, expB);
      end
      checks++;
      if (obs_now() !== expect_pair(S_MODE, a, b)) begin
         errors++;
         $display("FAIL s_special_model: got %h, expected %h", obs_now(), expect_pair(S_MODE, a, b));
      end
      $display("xfer S A=%h B=%h", a, b);
   endtask

   task automatic test_backpressure();
      logic        m [3];
      logic [63:0] a [3], b [3];
      logic [139:0] snap;
      int acc, got;
      for (int k = 0; k < 3; k++) begin
         m[k] = ($urandom_range(0, 1) == 1) ? D_MODE : S_MODE;
         a[k] = rand_op(m[k]);
         b[k] = rand_op(m[k]);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 clear = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1 clear = 1'b0;
      acc = 0;
      for (int c = 0; c < 5; c++) begin
         in_valid = (acc < 3); mode = m[acc % 3]; inA = a[acc % 3]; inB = b[acc % 3];
         #1;
         if (in_valid && in_ready) acc++;
         @(posedge clk); #1;
      end
      in_valid = (acc < 3); mode = m[acc % 3]; inA = a[acc % 3]; inB = b[acc % 3];
      #1;
      checks++;
      if (acc !== 2 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_accept: got accepted=%0d in_ready=%b, expected 2 and 0", acc, in_ready);
      end
      snap = obs_now();
      checks++;
      if (out_valid !== 1'b1 || snap !== expect_pair(m[0], a[0], b[0])) begin
         errors++;
         $display("FAIL bp_head: got valid=%b %h, expected 1 %h", out_valid, snap,
                  expect_pair(m[0], a[0], b[0]));
      end
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (obs_now() !== snap || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_stable: got %h, expected %h", obs_now(), snap);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 12; c++) begin
         in_valid = (acc < 3); mode = m[acc % 3]; inA = a[acc % 3]; inB = b[acc % 3];
         #1;
         if (in_valid && in_ready) acc++;
         if (out_valid) begin
            checks++;
            if (got >= 3 || obs_now() !== expect_pair(m[got % 3], a[got % 3], b[got % 3])) begin
               errors++;
               $display("FAIL bp_order: item %0d got %h, expected %h", got, obs_now(),
                        expect_pair(m[got % 3], a[got % 3], b[got % 3]));
            end
            $display("xfer bp item %0d A=%h B=%h", got, a[got % 3], b[got % 3]);
            got++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      checks++;
      if (got !== 3 || op_count !== 16'd3) begin
         errors++;
         $display("FAIL bp_count: got delivered=%0d op_count=%0d, expected 3 3", got, op_count);
      end
   endtask

   task automatic test_random();
      logic [139:0] exp_q [$];
      int           acc_q [$];
      logic [139:0] front, stall_obs;
      opx_t         ea, eb;
      logic         stalled, exp_ready, exp_valid, sticky_m;
      logic [15:0]  cnt_m;
      int           ecnt;
      in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
      repeat (4) @(posedge clk);
      #1 clear = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1 clear = 1'b0;
      sticky_m = 1'b0; cnt_m = '0; stalled = 1'b0; stall_obs = '0; ecnt = 0;
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         mode      = ($urandom_range(0, 1) == 1) ? D_MODE : S_MODE;
         inA       = rand_op(mode);
         inB       = rand_op(mode);
         out_ready = ($urandom_range(0, 99) < (((i / 50) % 2 == 1) ? 25 : 85));
         clear     = ($urandom_range(0, 19) == 0);
         #1;
         exp_ready = (exp_q.size() < 2) || out_ready;
         exp_valid = (exp_q.size() > 0) && (ecnt - acc_q[0] >= 1);
         checks++;
         if (in_ready !== exp_ready || out_valid !== exp_valid) begin
            errors++;
            $display("FAIL rand_handshake@%0d: got ready=%b valid=%b, expected %b %b",
                     i, in_ready, out_valid, exp_ready, exp_valid);
         end
         if (stalled && out_valid) begin
            checks++;
            if (obs_now() !== stall_obs) begin
               errors++;
               $display("FAIL rand_stall_hold@%0d: got %h, expected %h", i, obs_now(), stall_obs);
            end
         end
         if (out_valid && out_ready && exp_q.size() > 0) begin
            front = exp_q.pop_front();
            void'(acc_q.pop_front());
            checks++;
            if (obs_now() !== front) begin
               errors++;
               $display("FAIL rand_data@%0d: got %h, expected %h", i, obs_now(), front);
            end
            ea = front[139:70];
            eb = front[69:0];
            cnt_m    = cnt_m + 16'd1;
            sticky_m = sticky_m | ea.e | eb.e;
            $display("xfer rand %0d data=%h", i, front);
         end
         if (clear) begin
            cnt_m    = '0;
            sticky_m = 1'b0;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(expect_pair(mode, inA, inB));
            acc_q.push_back(ecnt + 1);
         end
         stalled   = out_valid && !out_ready;
         stall_obs = obs_now();
         @(posedge clk); ecnt++; #1;
         checks++;
         if (op_count !== cnt_m || err_sticky !== sticky_m) begin
            errors++;
            $display("FAIL rand_counters@%0d: got count=%0d sticky=%b, expected %0d %b",
                     i, op_count, err_sticky, cnt_m, sticky_m);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1; clear = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (out_valid && exp_q.size() > 0) begin
            front = exp_q.pop_front();
            void'(acc_q.pop_front());
            checks++;
            if (obs_now() !== front) begin
               errors++;
               $display("FAIL rand_drain: got %h, expected %h", obs_now(), front);
            end
         end
         @(posedge clk); #1;
      end
      checks++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rand_drain_empty: got %0d pending valid=%b, expected 0 0", exp_q.size(), out_valid);
      end
   endtask

   task automatic test_clear();
      logic pre_ok;
      drive_single(D_MODE, 64'h7FF0000000000001, 64'h3FF0000000000000);
      pre_ok = out_valid && errA;
      clear  = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      checks++;
      if (!pre_ok || err_sticky !== 1'b0 || op_count !== 16'd0) begin
         errors++;
         $display("FAIL clear_wins: got snan_present=%b sticky=%b count=%0d, expected 1 0 0",
                  pre_ok, err_sticky, op_count);
      end
   endtask

   task automatic test_reset_inflight();
      int bad;
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         mode = D_MODE; inA = rand_op(D_MODE); inB = rand_op(D_MODE); in_valid = 1'b1;
         @(posedge clk); #1;
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready, err_sticky, op_count} !== 19'd0 || obs_now() !== 140'd0) begin
         errors++;
         $display("FAIL inflight_reset: got valid=%b ready=%b count=%0d data=%h, expected all 0",
                  out_valid, in_ready, op_count, obs_now());
      end
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL inflight_release_ready: got %b, expected 1", in_ready);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         if (out_valid !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL inflight_stale: got %0d stale out_valid cycles, expected 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_s_normal();
      test_d_special();
      test_s_special();
      test_backpressure();
      test_random();
      test_clear();
      test_reset_inflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/input_interface.md
INPUT_INTERFACE -- requirements
Module: input_interface

Interface
REQ-001 The block SHALL use these ports (name  direction  width  meaning):
- clk  in  1  single clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  operation type: S_MODE (single) or D mode (double).
- inA, inB  in  REG_SIZE(64)  IEEE754 operands; S mode uses bits [31:0] only.
- in_valid / in_ready  in / out  1  upstream handshake.
- out_valid / out_ready  out / in  1  downstream handshake.
- intA, intB  out  53  significand with hidden bit, right-aligned.
- expA, expB  out  11  biased exponent; S mode zero-extended from 8 bits.
- signA, signB, nanA, nanB, infA, infB, zeroA, zeroB, denA, denB  out  1  classification flags.
- errA, errB  out  1  per-operand signalling-NaN flag.
- err_sticky  out  1  OR of all errA/errB delivered since reset or clear.
- clear  in  1  synchronous clear of err_sticky and op_count.
- op_count  out  16  number of output transfers completed; wraps at 16'hFFFF.

Function
REQ-002 The block SHALL be the exact inverse of the output-side packer: the operand unpacked here and repacked there SHALL reproduce the original word for every non-NaN input.
REQ-003 A transfer SHALL occur on a clock edge where in_valid and in_ready are both 1 (input) or out_valid and out_ready are both 1 (output).
REQ-004 The block SHALL be a two-stage pipeline: S1 registers {mode, inA, inB}; S2 registers the unpacked results. Latency from input transfer to out_valid SHALL be 2 cycles.
REQ-005 Each stage SHALL advance when it is valid and the next stage is empty or advancing in the same cycle; in_ready = !S1_valid | S1_advance. Full throughput of one operation per cycle SHALL be sustained while out_ready = 1.
REQ-006 With out_ready = 0, the block SHALL hold at most 2 operations, deassert in_ready when both stages are full, and never drop, duplicate or reorder operations.
REQ-007 Outputs SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-008 Field extraction (S / D): sign = bit 31 / 63; exp = [30:23] / [62:52]; man = [22:0] / [51:0].
REQ-009 Classification, evaluated on the per-mode exp and man fields:
- exp all ones, man = 0: inf.
- exp all ones, man != 0: nan.
- exp = 0, man = 0: zero.
- exp = 0, man != 0: den.
Otherwise the operand is normal and all flags are 0.
REQ-010 For normal operands, int = {1, man}. For zero and den operands, int = {0, man} and the reported exp SHALL be 1. For inf and nan, int = {0, man} and exp is the raw all-ones value.
REQ-011 errX SHALL be 1 when nanX = 1 and the man MSB (bit 22 in S mode, bit 51 in D mode) is 0 (signalling NaN).
REQ-012 err_sticky SHALL set on any output transfer carrying errA or errB.
REQ-013 op_count SHALL increment on each output transfer.
REQ-014 When clear coincides with an output transfer, clear SHALL win for both err_sticky and op_count.
REQ-015 In S mode, int bits [52:24] and exp bits [10:8] SHALL be 0.

Reset
REQ-016 While rst_n = 0, asynchronously: S1_valid, S2_valid, out_valid, err_sticky = 0; op_count = 0; all data outputs = 0; in_ready = 0.
REQ-017 in_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-018 Operations in flight when reset asserts SHALL be discarded.

Structure
REQ-019 REG_SIZE, S_MODE, the S and D exponent and mantissa widths, and the new constant INPUT_INTERFACE_INT_OUT = 53 SHALL live in the shared defs header.
REQ-020 A combinational sub-module fp_unpack (one operand plus mode in; int, exp and flags out) SHALL be instantiated twice, once for A and once for B.

Verification
REQ-021 S mode, inA = 32'h3F800000 -> 2 cycles later: intA = 53'h800000, expA = 11'h07F, all A flags 0.
REQ-022 D mode:
- inA = 64'h7FF0000000000000 -> infA = 1.
- inB = 64'hFFF8000000000000 -> nanB = 1, signB = 1, errB = 0.
- inA = 64'h7FF0000000000001 -> nanA = 1, errA = 1, err_sticky = 1 after the output transfer.
REQ-023 S mode:
- inA = 32'h00000001 -> denA = 1, intA = 1, expA = 1.
- inB = 32'h80000000 -> zeroB = 1, signB = 1, expB = 1.
REQ-024 Hold out_ready = 0 and offer 3 back-to-back operations -> exactly 2 accepted, in_ready = 0, outputs stable. Then set out_ready = 1 -> all 3 delivered in order, op_count = 3.
REQ-025 Drop rst_n with both stages full -> out_valid = 0 and op_count = 0 immediately. After release, in_ready = 1 and no stale data appears.
REQ-026 Assert clear in the same cycle as an sNaN output transfer -> err_sticky = 0 and op_count = 0 on the next cycle.
